config_loader: RTL

Configuration master for the PE tile array. Accepts a byte-serial bitstream over a valid/ready handshake and assembles 8-byte records of 32-bit address plus 32-bit data. Each record is driven onto the shared `config_addr`/`config_data` bus for exactly one clock edge. Every tile decodes that bus against its `tile_id` (bits [15:0]) and sub-block select (bits [31:16]: 7=SB, 6=CB0, 5=CB1, 4=CLB).

---
 rtl/config_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/config_loader.sv
// Byte-serial configuration master: assembles big-endian {addr, data} records from a
// valid/ready byte stream and pulses each one onto the tile config bus for a single cycle.
module config_loader #(
   parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
   parameter logic [31:0] END_ADDR  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        config_write,
   output logic        done,
   output logic [15:0] record_count
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [2:0]  byte_cnt;
   logic [55:0] shift_p0;
   logic [63:0] record_full;
   logic        xfer;
   logic        load_write;
   logic        enter_done;

   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

   // The eighth byte completes the record straight from the input, with no extra cycle.
   assign record_full = {shift_p0, in_data};

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      xfer       = 1'b0;
      load_write = 1'b0;
      enter_done = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            xfer     = in_valid;
            if (in_valid && (byte_cnt == 3'd7)) begin
               if (record_full[63:32] == END_ADDR) begin
                  state_next = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_next = WRITE;
                  load_write = 1'b1;
               end
            end
         end
         WRITE:   state_next = COLLECT;
         DONE:    state_next = DONE;
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   // Byte assembly stage: a partial record left behind by reset is simply overwritten.
   always_ff @(posedge clk) begin
      if (xfer) begin
         shift_p0 <= record_full[55:0];
      end
   end

   // Bus stage: one-cycle write pulse, address parks at IDLE_ADDR, data holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt     <= 3'd0;
         config_addr  <= IDLE_ADDR;
         config_data  <= 32'd0;
         config_write <= 1'b0;
         done         <= 1'b0;
         record_count <= 16'd0;
      end else begin
         if (xfer) begin
            byte_cnt <= byte_cnt + 3'd1;
         end
         config_write <= load_write;
         if (load_write) begin
            config_addr  <= record_full[63:32];
            config_data  <= record_full[31:0];
            record_count <= sat_inc(record_count);
         end else begin
            config_addr <= IDLE_ADDR;
         end
         if (enter_done) begin
            done <= 1'b1;
         end
      end
   end

endmodule
